// File: rtl/srjf_pkg.sv
// Shared types and default constants for the SRJF task scheduler.
// The optional statistics counters are controlled by the SRJF_STATS_EN macro
// in srjf_sched_param.
package srjf_pkg;

    localparam int NUM_SLOTS_DEF = 5;
    localparam int REM_W_DEF     = 4;
    localparam int ID_W_DEF      = 16;
    localparam int AGE_W_DEF     = 6;

    typedef enum logic {
        S_INIT = 1'b0,
        S_EXEC = 1'b1
    } srjf_state_e;

    // One resident task slot at the default widths.
    typedef struct packed {
        logic [REM_W_DEF-1:0] rem;
        logic [AGE_W_DEF-1:0] age;
        logic [ID_W_DEF-1:0]  id;
    } slot_t;

    // Value driven on task_out when nothing is served.
    localparam logic [ID_W_DEF-1:0] TASK_OUT_IDLE = '1;

endpackage

// File: rtl/srjf_min_select.sv
// Combinational argmin over the resident slots: smallest remaining time wins,
// ties go to the oldest slot, remaining ties go to the lowest index.
module srjf_min_select #(
    parameter int N     = 5,
    parameter int REM_W = 4,
    parameter int AGE_W = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             en,
    input  logic [REM_W-1:0] rem [N],
    input  logic [AGE_W-1:0] age [N],
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_valid
);

    logic [REM_W-1:0] best_rem;
    logic [AGE_W-1:0] best_age;

    // Scan in index order; strict comparisons keep the lowest index on full ties.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_rem  = '0;
        best_age  = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (rem[i] != '0)) begin
                if (!sel_valid || (rem[i] < best_rem) ||
                    ((rem[i] == best_rem) && (age[i] > best_age))) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDX_W'(i);
                    best_rem  = rem[i];
                    best_age  = age[i];
                end
            end
        end
    end

endmodule

// File: rtl/srjf_sched_param.sv
// Shortest-Remaining-Job-First scheduler with NUM_SLOTS resident task slots.
// Grants one service unit per cycle to the selected slot.
// Valid/ready: a task is transferred on every rising edge where
// in_valid && in_ready; in_ready never depends on in_valid.
// Optional statistics counters: define SRJF_STATS_EN.
module srjf_sched_param
    import srjf_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int REM_W     = REM_W_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int AGE_W     = AGE_W_DEF,
    parameter int OCC_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REM_W+ID_W-1:0] task_in,
    output logic                  task_valid,
    output logic [ID_W-1:0]       task_out,
    output logic                  done,
    output logic                  empty,
    output logic [OCC_W-1:0]      occupancy,
    output srjf_state_e           state_dbg
`ifdef SRJF_STATS_EN
    ,
    output logic [31:0]           stat_done_cnt,
    output logic [31:0]           stat_busy_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    srjf_state_e      state_q, state_d;
    logic [REM_W-1:0] rem_q [NUM_SLOTS];
    logic [AGE_W-1:0] age_q [NUM_SLOTS];
    logic [ID_W-1:0]  id_q  [NUM_SLOTS];

    logic [OCC_W-1:0] occ;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             accept;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [REM_W-1:0] new_rem;
    logic [ID_W-1:0]  new_id;

    assign new_rem = task_in[REM_W+ID_W-1:ID_W];
    assign new_id  = task_in[ID_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next state: leave S_INIT on start, then remain in S_EXEC until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (st) state_d = S_EXEC;
            S_EXEC:  state_d = S_EXEC;
            default: state_d = S_INIT;
        endcase
    end

    assign state_dbg = state_q;

    // Occupancy count and lowest-index free slot from the registered state only,
    // so a slot emptied this cycle is not reused until the next one.
    always_comb begin
        occ        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rem_q[i] != '0) begin
                occ = occ + OCC_W'(1);
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign in_ready  = (state_q == S_EXEC) && (occ < OCC_W'(NUM_SLOTS));
    assign accept    = in_valid && in_ready;
    assign empty     = (occ == '0);
    assign occupancy = occ;

    srjf_min_select #(
        .N     (NUM_SLOTS),
        .REM_W (REM_W),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_min_select (
        .en        (state_q == S_EXEC),
        .rem       (rem_q),
        .age       (age_q),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    assign task_valid = sel_valid;
    assign task_out   = sel_valid ? id_q[sel_idx] : '1;
    assign done       = sel_valid && (rem_q[sel_idx] == REM_W'(1));

    // Slot update: serve the selected slot, age the waiting ones, fill a free
    // slot with an accepted task. A free slot is never the selected one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                rem_q[i] <= '0;
                age_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else if (state_q == S_INIT) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                rem_q[i] <= '0;
                age_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (sel_valid && (sel_idx == IDX_W'(i))) begin
                    rem_q[i] <= rem_q[i] - REM_W'(1);
                    if (rem_q[i] == REM_W'(1)) age_q[i] <= '0;
                end else if (rem_q[i] != '0) begin
                    if (age_q[i] != '1) age_q[i] <= age_q[i] + AGE_W'(1);
                end else if (accept && (free_idx == IDX_W'(i))) begin
                    rem_q[i] <= new_rem;
                    age_q[i] <= '0;
                    id_q[i]  <= new_id;
                end
            end
        end
    end

`ifdef SRJF_STATS_EN
    // Completion and busy-cycle counters, wrapping, held at zero in S_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done_cnt <= '0;
            stat_busy_cnt <= '0;
        end else if (state_q == S_INIT) begin
            stat_done_cnt <= '0;
            stat_busy_cnt <= '0;
        end else begin
            if (done)       stat_done_cnt <= stat_done_cnt + 32'd1;
            if (task_valid) stat_busy_cnt <= stat_busy_cnt + 32'd1;
        end
    end
`endif

endmodule
